// File: rtl/inst_mem_loader_pkg.sv
// rtl/inst_mem_loader_pkg.sv - shared constants, state encoding and width helpers for the loader
package inst_mem_loader_pkg;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_DONE     = 2'd2,
    ST_OVERFLOW = 2'd3
  } state_t;

  // Counter must be able to hold the value "full", hence size+1.
  function automatic int cnt_w(input int size);
    return (size < 1) ? 1 : $clog2(size + 1);
  endfunction

  function automatic int idx_w(input int size);
    return (size <= 1) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/inst_mem_loader_ram.sv
// rtl/inst_mem_loader_ram.sv - single-port-write, synchronous read-first instruction RAM
module inst_ram #(
  parameter int DEPTH = 25,
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-index read returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - writes assembled instruction words into RAM until HALT or overflow
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int              MEM_INST_SIZE = 25,
  parameter int              DATA_W        = 32,
  parameter logic [DATA_W-1:0] HALT_WORD   = DATA_W'(DEFAULT_HALT_WORD)
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic [DATA_W-1:0]                 i_word,
  input  logic                              i_word_valid,
  input  logic [31:0]                       i_rd_addr,
  output logic [DATA_W-1:0]                 o_rd_data,
  output logic [cnt_w(MEM_INST_SIZE)-1:0]   o_word_count,
  output logic                              o_busy,
  output logic                              o_load_done,
  output logic                              o_overflow
);

  localparam int CNT_W = cnt_w(MEM_INST_SIZE);
  localparam int IDX_W = idx_w(MEM_INST_SIZE);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MEM_INST_SIZE);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    count;
  logic                wr_en;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_in_range;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   ram_rdata;
  logic                unused_addr_bits;

  assign wr_en = (state == ST_LOAD) && i_word_valid && (count != FULL);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: begin
        if (i_word_valid) begin
          if (count == FULL) begin
            state_next = ST_OVERFLOW;
          end else if (i_word == HALT_WORD) begin
            state_next = ST_DONE;
          end
        end
      end
      default: begin
        if (i_start) begin
          state_next = ST_LOAD;
        end
      end
    endcase
  end

  always_comb begin
    o_busy      = (state == ST_LOAD);
    o_load_done = (state == ST_DONE);
    o_overflow  = (state == ST_OVERFLOW);
  end

  // Saturates at FULL because wr_en is blocked once the memory is full.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if ((state != ST_LOAD) && i_start) begin
      count <= '0;
    end else if (wr_en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign o_word_count = count;

  assign rd_idx      = i_rd_addr[IDX_W+1:2];
  assign rd_in_range = ({1'b0, rd_idx} < (IDX_W+1)'(MEM_INST_SIZE)) &&
                       (i_rd_addr[31:IDX_W+2] == '0);
  assign unused_addr_bits = ^i_rd_addr[1:0];

  // The RAM array has no reset, so the zero/out-of-range result is applied after it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_in_range;
    end
  end

  inst_ram #(
    .DEPTH (MEM_INST_SIZE),
    .WIDTH (DATA_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (i_clk),
    .we    (wr_en),
    .waddr (count[IDX_W-1:0]),
    .wdata (i_word),
    .raddr (rd_in_range ? rd_idx : '0),
    .rdata (ram_rdata)
  );

  assign o_rd_data = rd_valid_q ? ram_rdata : '0;

endmodule
